pulse_generator: RTL

- Programmable square-wave source: drives FREQ_OUT with exact, cycle-accurate low and high durations counted in CLK cycles.
- Transmit-side counterpart to frequency_counter. It produces the waveform that the counter measures, and in loopback the two blocks form a self-test pair.
- New timing is taken through a valid/ready handshake and applied only on period boundaries, so no runt pulses appear.

---
 rtl/pulse_gen_pkg.sv | 14 +
 rtl/phase_timer.sv | 25 ++
 rtl/pulse_generator.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pulse_gen_pkg.sv
// rtl/pulse_gen_pkg.sv - shared types and constants for pulse_generator and frequency_counter
package pulse_gen_pkg;

    localparam int DEF_COUNTER_BITS = 16;
    localparam int DEF_CYCLE_BITS   = 32;
    localparam int MIN_PHASE        = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } pg_state_e;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter that times one waveform phase
module phase_timer #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             zero
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/pulse_generator.sv
// rtl/pulse_generator.sv - programmable square-wave source with boundary-aligned reconfiguration
module pulse_generator
    import pulse_gen_pkg::*;
#(
    parameter int COUNTER_BITS = DEF_COUNTER_BITS,
    parameter int CYCLE_BITS   = DEF_CYCLE_BITS
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    ENABLE,
    input  logic                    CFG_VALID,
    output logic                    CFG_READY,
    input  logic [COUNTER_BITS-1:0] CFG_LOW,
    input  logic [COUNTER_BITS-1:0] CFG_HIGH,
    output logic                    FREQ_OUT,
    output logic                    PERIOD_DONE,
    output logic [CYCLE_BITS-1:0]   CYCLE_COUNT,
    output logic                    ACTIVE
);

    localparam logic [COUNTER_BITS-1:0] PHASE_MIN = COUNTER_BITS'(MIN_PHASE);

    pg_state_e               state, state_nxt;
    logic [COUNTER_BITS-1:0] act_low, act_high;
    logic [COUNTER_BITS-1:0] pend_low, pend_high;
    logic                    pend_full;
    logic                    accept, promote;
    logic                    load;
    logic [COUNTER_BITS-1:0] load_val, next_low, cnt;
    logic                    cnt_zero;

    assign CFG_READY   = !pend_full;
    assign accept      = CFG_VALID && !pend_full;
    assign next_low    = pend_full ? pend_low : act_low;
    assign PERIOD_DONE = (state == HIGH) && cnt_zero;
    assign ACTIVE      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        promote   = 1'b0;
        load      = 1'b0;
        load_val  = next_low - 1'b1;
        case (state)
            IDLE: begin
                if (ENABLE) begin
                    state_nxt = LOW;
                    promote   = pend_full;
                    load      = 1'b1;
                end
            end
            LOW: begin
                if (cnt_zero) begin
                    state_nxt = HIGH;
                    load      = 1'b1;
                    load_val  = act_high - 1'b1;
                end
            end
            HIGH: begin
                // ENABLE only matters at the period end so a high pulse is never cut short
                if (cnt_zero) begin
                    if (ENABLE) begin
                        state_nxt = LOW;
                        promote   = pend_full;
                        load      = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            FREQ_OUT    <= 1'b0;
            CYCLE_COUNT <= '0;
        end else begin
            state    <= state_nxt;
            FREQ_OUT <= (state_nxt == HIGH);
            if (PERIOD_DONE) begin
                CYCLE_COUNT <= CYCLE_COUNT + 1'b1;
            end
        end
    end

    // Zero-length requests are widened to the minimum phase at capture time
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            act_low   <= PHASE_MIN;
            act_high  <= PHASE_MIN;
            pend_low  <= PHASE_MIN;
            pend_high <= PHASE_MIN;
            pend_full <= 1'b0;
        end else begin
            if (promote) begin
                act_low   <= pend_low;
                act_high  <= pend_high;
                pend_full <= 1'b0;
            end else if (accept) begin
                pend_low  <= (CFG_LOW  == '0) ? PHASE_MIN : CFG_LOW;
                pend_high <= (CFG_HIGH == '0) ? PHASE_MIN : CFG_HIGH;
                pend_full <= 1'b1;
            end
        end
    end

    phase_timer #(
        .WIDTH(COUNTER_BITS)
    ) u_phase_timer (
        .CLK       (CLK),
        .RST       (RST),
        .load      (load),
        .load_value(load_val),
        .value     (cnt),
        .zero      (cnt_zero)
    );

endmodule
